ff_bank: RTL and testbench

Parametrised bank of WIDTH independent single-bit flip-flops sharing one clock, enable and run-time mode select (SR, JK, D, T). It is the multi-channel successor to the single SR flip-flop in the digital-logic library. It adds a configurable policy for the forbidden SR input, an exactly complementary output at every edge, and registered detection and counting of forbidden-input events. It sits wherever the lab designs need a register of latches or toggles driven by switches or counter logic.

---
 rtl/ff_bank.sv | 137 +++++++++++++
 tb/tb_ff_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : ff_bank
// Description : Bank of WIDTH independent single-bit flip-flops. All channels
//               share the clock, an update enable and a run-time mode select
//               (SR, JK, D, T). The policy for the forbidden SR input (S=R=1)
//               is chosen at build time. Forbidden-input events are reported
//               as a registered one-cycle pulse, a sticky flag and a
//               saturating event counter.
// Ports       : clk        - clock, all state updates on the rising edge
//               rst        - synchronous active-high reset
//               en         - update enable (0 = every channel holds)
//               mode[1:0]  - 00 SR, 01 JK, 10 D, 11 T
//               a[WIDTH]   - per-channel S / J / D / T
//               b[WIDTH]   - per-channel R / K (unused in D and T)
//               err_clr    - clears err_sticky and err_count
//               q, q_n     - channel state and its exact complement
//               invalid    - one-cycle flag for a forbidden SR input
//               err_sticky - set on any forbidden SR input until cleared
//               err_count  - saturating count of forbidden-input cycles
// Revision    : 1.0 - initial release
// ============================================================================
module ff_bank #(
    parameter int                WIDTH             = 8,
    parameter int                CNT_W             = 8,
    parameter int                SR_INVALID_POLICY = 0,
    parameter logic [WIDTH-1:0]  RESET_VALUE       = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_n,
    output logic              invalid,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [1:0] c_MODE_SR = 2'b00;
    localparam logic [1:0] c_MODE_JK = 2'b01;
    localparam logic [1:0] c_MODE_D  = 2'b10;
    localparam logic [1:0] c_MODE_T  = 2'b11;

    localparam int         c_POL_SET   = 1;
    localparam int         c_POL_RESET = 2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_q_n;
    logic             r_invalid;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic             w_forbidden;

    // One event per edge no matter how many channels see S=R=1.
    assign w_forbidden = en && (mode == c_MODE_SR) && (|(a & b));

    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                c_MODE_SR: begin
                    case ({a[i], b[i]})
                        2'b10:   w_q_next[i] = 1'b1;
                        2'b01:   w_q_next[i] = 1'b0;
                        2'b11: begin
                            // Policy values other than set/reset (0 and 3) hold.
                            if (SR_INVALID_POLICY == c_POL_SET)
                                w_q_next[i] = 1'b1;
                            else if (SR_INVALID_POLICY == c_POL_RESET)
                                w_q_next[i] = 1'b0;
                            else
                                w_q_next[i] = r_q[i];
                        end
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
                c_MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b10:   w_q_next[i] = 1'b1;
                        2'b01:   w_q_next[i] = 1'b0;
                        2'b11:   w_q_next[i] = ~r_q[i];
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
                c_MODE_D: w_q_next[i] = a[i];
                c_MODE_T: w_q_next[i] = r_q[i] ^ a[i];
                default:  w_q_next[i] = r_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RESET_VALUE;
            r_q_n     <= ~RESET_VALUE;
            r_invalid <= 1'b0;
            r_sticky  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            // q_n is a separate register loaded from the same next-state
            // value so it is the exact complement at every edge.
            if (en) begin
                r_q   <= w_q_next;
                r_q_n <= ~w_q_next;
            end
            r_invalid <= w_forbidden;
            if (w_forbidden) begin
                // A simultaneous clear restarts the count at this event.
                r_sticky <= 1'b1;
                if (err_clr)
                    r_cnt <= c_CNT_ONE;
                else if (r_cnt != c_CNT_MAX)
                    r_cnt <= r_cnt + c_CNT_ONE;
            end else if (err_clr) begin
                r_sticky <= 1'b0;
                r_cnt    <= '0;
            end
        end
    end

    assign q          = r_q;
    assign q_n        = r_q_n;
    assign invalid    = r_invalid;
    assign err_sticky = r_sticky;
    assign err_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff_bank
// Description : Directed bench for ff_bank. Three instances share stimulus,
//               one per forbidden-input policy (hold / set / reset). The hold
//               and set instances use a 2-bit counter to reach saturation,
//               the reset instance keeps the default 8-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_bank;

    logic       clk = 1'b0;
    logic       rst, en, err_clr;
    logic [1:0] mode;
    logic [7:0] a, b;

    logic [7:0] q0, qn0, q1, qn1, q2, qn2;
    logic       inv0, inv1, inv2, st0, st1, st2;
    logic [1:0] cnt0, cnt1;
    logic [7:0] cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ff_bank #(.WIDTH(8), .CNT_W(2), .SR_INVALID_POLICY(0), .RESET_VALUE(8'hA5)) u_p0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q0), .q_n(qn0), .invalid(inv0), .err_sticky(st0), .err_count(cnt0));
    ff_bank #(.WIDTH(8), .CNT_W(2), .SR_INVALID_POLICY(1), .RESET_VALUE(8'hA5)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q1), .q_n(qn1), .invalid(inv1), .err_sticky(st1), .err_count(cnt1));
    ff_bank #(.WIDTH(8), .CNT_W(8), .SR_INVALID_POLICY(2), .RESET_VALUE(8'hA5)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q2), .q_n(qn2), .invalid(inv2), .err_sticky(st2), .err_count(cnt2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] va, input logic [7:0] vb, input logic c);
        rst = r; en = e; mode = m; a = va; b = vb; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    // q and q_n of all three instances.
    task automatic chk_q(input string tag, input logic [7:0] e0,
                         input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] n0, n1, n2;
        n0 = ~e0; n1 = ~e1; n2 = ~e2;
        chk({tag, ".q0"}, q0, e0);   chk({tag, ".qn0"}, qn0, n0);
        chk({tag, ".q1"}, q1, e1);   chk({tag, ".qn1"}, qn1, n1);
        chk({tag, ".q2"}, q2, e2);   chk({tag, ".qn2"}, qn2, n2);
    endtask

    // Error flags; the 2-bit and 8-bit counters are given separately.
    task automatic chk_err(input string tag, input logic inv, input logic st,
                           input logic [1:0] c_narrow, input logic [7:0] c_wide);
        chk({tag, ".inv0"}, inv0, inv);  chk({tag, ".inv1"}, inv1, inv);
        chk({tag, ".inv2"}, inv2, inv);
        chk({tag, ".st0"}, st0, st);     chk({tag, ".st2"}, st2, st);
        chk({tag, ".cnt0"}, cnt0, c_narrow);
        chk({tag, ".cnt1"}, cnt1, c_narrow);
        chk({tag, ".cnt2"}, cnt2, c_wide);
    endtask

    localparam logic [1:0] SR = 2'b00, JK = 2'b01, D = 2'b10, T = 2'b11;

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset
        cyc(1, 0, SR, 8'h00, 8'h00, 0);
        chk_q("rst", 8'hA5, 8'hA5, 8'hA5);
        chk_err("rst", 0, 0, 2'd0, 8'd0);
        cyc(1, 1, T, 8'hFF, 8'h00, 0);
        chk_q("rst_busy", 8'hA5, 8'hA5, 8'hA5);

        // SR / JK
        cyc(0, 1, D, 8'h00, 8'h00, 0);
        chk_q("d_zero", 8'h00, 8'h00, 8'h00);
        cyc(0, 1, SR, 8'h0F, 8'hF0, 0);
        chk_q("sr", 8'h0F, 8'h0F, 8'h0F);
        chk_err("sr", 0, 0, 2'd0, 8'd0);
        cyc(0, 1, JK, 8'hFF, 8'hFF, 0);
        chk_q("jk_tog", 8'hF0, 8'hF0, 8'hF0);
        cyc(0, 1, JK, 8'h00, 8'h00, 0);
        chk_q("jk_hold", 8'hF0, 8'hF0, 8'hF0);
        cyc(0, 1, JK, 8'h0C, 8'h30, 0);
        chk_q("jk_sr", 8'hCC, 8'hCC, 8'hCC);

        // D / T / enable
        cyc(0, 1, D, 8'h3C, 8'h00, 0);
        chk_q("d", 8'h3C, 8'h3C, 8'h3C);
        cyc(0, 1, T, 8'h01, 8'hFF, 0);
        chk_q("t", 8'h3D, 8'h3D, 8'h3D);
        cyc(0, 0, T, 8'hFF, 8'h00, 0);
        chk_q("en0", 8'h3D, 8'h3D, 8'h3D);

        // Forbidden policies
        cyc(0, 1, D, 8'h0F, 8'h00, 0);
        chk_q("pre_bad", 8'h0F, 8'h0F, 8'h0F);
        cyc(0, 1, SR, 8'hFF, 8'hFF, 0);
        chk_q("bad", 8'h0F, 8'hFF, 8'h00);
        chk_err("bad", 1, 1, 2'd1, 8'd1);
        cyc(0, 1, SR, 8'h00, 8'h00, 0);
        chk_q("bad_after", 8'h0F, 8'hFF, 8'h00);
        chk_err("bad_after", 0, 1, 2'd1, 8'd1);
        // Single offending channel among valid ones
        cyc(0, 1, SR, 8'h81, 8'h01, 0);
        chk_q("bad_one", 8'h8F, 8'hFF, 8'h80);
        chk_err("bad_one", 1, 1, 2'd2, 8'd2);

        // Clear, saturation, clear variants
        cyc(0, 1, SR, 8'h00, 8'h00, 1);
        chk_err("clr", 0, 0, 2'd0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, SR, 8'hFF, 8'hFF, 0);
            chk_err($sformatf("sat%0d", k), 1, 1, sat_exp[k], 8'(k + 1));
        end
        cyc(0, 1, SR, 8'h00, 8'h00, 1);
        chk_err("clr2", 0, 0, 2'd0, 8'd0);
        cyc(0, 1, SR, 8'hFF, 8'hFF, 1);
        chk_err("clr_evt", 1, 1, 2'd1, 8'd1);
        cyc(0, 0, SR, 8'hFF, 8'hFF, 0);
        chk_err("en0_bad", 0, 1, 2'd1, 8'd1);
        cyc(0, 0, SR, 8'hFF, 8'hFF, 1);
        chk_err("en0_clr", 0, 0, 2'd0, 8'd0);

        // Reset mid-burst
        cyc(0, 1, SR, 8'hFF, 8'hFF, 0);
        cyc(0, 1, SR, 8'hFF, 8'hFF, 0);
        chk_err("burst", 1, 1, 2'd2, 8'd2);
        cyc(1, 1, SR, 8'hFF, 8'hFF, 1);
        chk_q("burst_rst", 8'hA5, 8'hA5, 8'hA5);
        chk_err("burst_rst", 0, 0, 2'd0, 8'd0);
        cyc(0, 1, SR, 8'hFF, 8'hFF, 0);
        chk_q("post_rst", 8'hA5, 8'hFF, 8'h00);
        chk_err("post_rst", 1, 1, 2'd1, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
